// File: rtl/branch_stall_controller.sv
// -----------------------------------------------------------------------------
// branch_stall_controller
//
// ID-stage sequencing for the branch-resolution path of the 5-stage pipeline.
// Holds PC and IF/ID while a branch operand cannot yet be forwarded from MEM
// or read write-first from the register file. Injects bubbles into ID/EX,
// handles classic load-use stalls for non-branches, and flushes IF/ID on a
// taken branch. Also keeps saturating counters of stall cycles and taken
// branches.
//
// Ports
//   clk, rst_n                 pipeline clock, async active-low reset
//   ID_Branch                  ID holds a conditional branch / register jump
//   ID_Ra, ID_Rb, ID_UsesRb    ID source registers, Rb valid flag
//   EX_Rw, EX_RegWr            EX destination / write enable
//   EX_MemtoReg                EX instruction is a load
//   Mem_Rw, Mem_RegWr          MEM destination / write enable
//   Mem_MemtoReg               MEM instruction is a load
//   BranchTaken                ID comparator result on forwarded operands
//   Ext_Stall                  external freeze, overrides everything
//   PC_Write, IFID_Write       PC / IF/ID load enables
//   IDEX_Bubble                load a NOP into ID/EX
//   IFID_Flush                 clear IF/ID on a taken branch
//   StallCycles                saturating count of bubble cycles
//   TakenBranches              saturating count of flush cycles
// -----------------------------------------------------------------------------
module branch_stall_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Branch,
  input  logic [4:0]       ID_Ra,
  input  logic [4:0]       ID_Rb,
  input  logic             ID_UsesRb,
  input  logic [4:0]       EX_Rw,
  input  logic [4:0]       Mem_Rw,
  input  logic             EX_RegWr,
  input  logic             Mem_RegWr,
  input  logic             EX_MemtoReg,
  input  logic             Mem_MemtoReg,
  input  logic             BranchTaken,
  input  logic             Ext_Stall,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] TakenBranches
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_next;

  // A producer matches a source when it writes a non-zero register equal to it.
  function automatic logic reg_hit(input logic wr, input logic [4:0] rw,
                                   input logic [4:0] src);
    return wr && (rw != 5'd0) && (rw == src);
  endfunction

  logic ex_hit, mem_hit;
  logic need_two, need_stall;

  always_comb begin
    ex_hit  = reg_hit(EX_RegWr, EX_Rw, ID_Ra) ||
              (ID_UsesRb && reg_hit(EX_RegWr, EX_Rw, ID_Rb));
    mem_hit = reg_hit(Mem_RegWr, Mem_Rw, ID_Ra) ||
              (ID_UsesRb && reg_hit(Mem_RegWr, Mem_Rw, ID_Rb));

    // Depth 2 only arises from a branch waiting on an EX load. Any deeper
    // hazard on one operand dominates a shallower one on the other.
    need_two = ID_Branch && ex_hit && EX_MemtoReg;

    // A branch needs every operand in MEM as an ALU result or in the register
    // file; a MEM load result is not forwardable to the comparator yet.
    if (ID_Branch)
      need_stall = ex_hit || (mem_hit && Mem_MemtoReg);
    else
      need_stall = ex_hit && EX_MemtoReg;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    state_next  = state;

    if (!rst_n) begin
      // Outputs sit at the free-running values while reset is held.
      state_next = RUN;
    end else if (Ext_Stall) begin
      // Full freeze: no bubble, no flush, state unchanged.
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          // Second stall cycle of an EX-load branch; hazards not re-examined.
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          state_next  = RUN;
        end
        default: begin
          if (need_stall) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            state_next  = need_two ? HOLD : RUN;
          end else begin
            IFID_Flush = ID_Branch && BranchTaken;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Bubble and flush are already forced low during Ext_Stall, so the counters
  // hold then without a separate qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles   <= '0;
      TakenBranches <= '0;
    end else begin
      if (IDEX_Bubble && (StallCycles != '1))
        StallCycles <= StallCycles + 1'b1;
      if (IFID_Flush && (TakenBranches != '1))
        TakenBranches <= TakenBranches + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_branch_stall_controller
//
// Directed and randomized stimulus for branch_stall_controller. The reference
// model tracks only "stall cycles still owed" plus two integer counters and
// derives the required stall depth directly from the hazard rules.
// -----------------------------------------------------------------------------
module tb_branch_stall_controller;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ID_Branch, ID_UsesRb, BranchTaken, Ext_Stall;
  logic [4:0]       ID_Ra, ID_Rb, EX_Rw, Mem_Rw;
  logic             EX_RegWr, Mem_RegWr, EX_MemtoReg, Mem_MemtoReg;
  logic             PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic [CNT_W-1:0] StallCycles, TakenBranches;

  branch_stall_controller #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_Branch    (ID_Branch),
    .ID_Ra        (ID_Ra),
    .ID_Rb        (ID_Rb),
    .ID_UsesRb    (ID_UsesRb),
    .EX_Rw        (EX_Rw),
    .Mem_Rw       (Mem_Rw),
    .EX_RegWr     (EX_RegWr),
    .Mem_RegWr    (Mem_RegWr),
    .EX_MemtoReg  (EX_MemtoReg),
    .Mem_MemtoReg (Mem_MemtoReg),
    .BranchTaken  (BranchTaken),
    .Ext_Stall    (Ext_Stall),
    .PC_Write     (PC_Write),
    .IFID_Write   (IFID_Write),
    .IDEX_Bubble  (IDEX_Bubble),
    .IFID_Flush   (IFID_Flush),
    .StallCycles  (StallCycles),
    .TakenBranches(TakenBranches)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int n_total = 0;
  int n_pass  = 0;
  int owed    = 0;   // stall cycles still owed without re-examining hazards
  int m_stall = 0;
  int m_taken = 0;
  int cur_d   = 0;
  logic e_pcw, e_ifidw, e_bub, e_flush;

  function automatic int hazard_depth();
    int d = 0;
    logic [4:0] srcs[2];
    int nsrc;
    srcs[0] = ID_Ra;
    srcs[1] = ID_Rb;
    nsrc = ID_UsesRb ? 2 : 1;
    for (int i = 0; i < nsrc; i++) begin
      bit ex_m, mem_m;
      ex_m  = EX_RegWr  && EX_Rw  != 0 && EX_Rw  == srcs[i];
      mem_m = Mem_RegWr && Mem_Rw != 0 && Mem_Rw == srcs[i];
      if (ID_Branch) begin
        if (ex_m && EX_MemtoReg)        d = (d > 2) ? d : 2;
        else if (ex_m)                  d = (d > 1) ? d : 1;
        if (mem_m && Mem_MemtoReg)      d = (d > 1) ? d : 1;
      end else if (ex_m && EX_MemtoReg) d = (d > 1) ? d : 1;
    end
    return d;
  endfunction

  task automatic predict();
    cur_d = hazard_depth();
    if (!rst_n) begin
      {e_pcw, e_ifidw, e_bub, e_flush} = 4'b1100;
    end else if (Ext_Stall) begin
      {e_pcw, e_ifidw, e_bub, e_flush} = 4'b0000;
    end else if (owed > 0 || cur_d > 0) begin
      {e_pcw, e_ifidw, e_bub, e_flush} = 4'b0010;
    end else begin
      {e_pcw, e_ifidw, e_bub} = 3'b110;
      e_flush = ID_Branch && BranchTaken;
    end
  endtask

  task automatic advance();
    if (!rst_n) begin
      owed = 0; m_stall = 0; m_taken = 0;
    end else if (!Ext_Stall) begin
      if (e_bub   && m_stall < CNT_MAX) m_stall++;
      if (e_flush && m_taken < CNT_MAX) m_taken++;
      if (owed > 0)       owed = owed - 1;
      else if (cur_d > 0) owed = cur_d - 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PC_Write"},      32'(PC_Write),      32'(e_pcw));
    check({tag, ".IFID_Write"},    32'(IFID_Write),    32'(e_ifidw));
    check({tag, ".IDEX_Bubble"},   32'(IDEX_Bubble),   32'(e_bub));
    check({tag, ".IFID_Flush"},    32'(IFID_Flush),    32'(e_flush));
    check({tag, ".StallCycles"},   32'(StallCycles),   32'(m_stall));
    check({tag, ".TakenBranches"}, 32'(TakenBranches), 32'(m_taken));
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 time unit
  // later, then the model advances on the rising edge.
  task automatic step(input string tag);
    #1;
    predict();
    check_all(tag);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    predict();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle();
    ID_Branch = 0; ID_Ra = 0; ID_Rb = 0; ID_UsesRb = 0;
    EX_Rw = 0; Mem_Rw = 0; EX_RegWr = 0; Mem_RegWr = 0;
    EX_MemtoReg = 0; Mem_MemtoReg = 0; BranchTaken = 0; Ext_Stall = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step("reset");
    rst_n = 1'b1;
    step("post_reset");

    // Branch on r5 with EX ALU producer: one stall, then taken resolve.
    ID_Branch = 1; ID_Ra = 5; EX_Rw = 5; EX_RegWr = 1;
    step("br_ex_alu_stall");
    EX_RegWr = 0; BranchTaken = 1;
    step("br_ex_alu_resolve");
    idle();
    step("br_ex_alu_counts");

    // Branch on Rb=r7 with EX load: RUN stall, HOLD stall, resolve.
    ID_Branch = 1; ID_Ra = 1; ID_Rb = 7; ID_UsesRb = 1;
    EX_Rw = 7; EX_RegWr = 1; EX_MemtoReg = 1;
    step("br_ex_load_run");
    EX_Rw = 9;  // hazard gone, HOLD must still stall
    step("br_ex_load_hold");
    EX_RegWr = 0; EX_MemtoReg = 0;
    step("br_ex_load_resolve");

    // r0 never hazards; flush follows BranchTaken in the same cycle.
    idle();
    ID_Branch = 1; EX_RegWr = 1; BranchTaken = 1;
    step("br_r0_taken");
    BranchTaken = 0;
    step("br_r0_not_taken");

    // Non-branch load-use: one bubble. MEM load on non-branch: no stall.
    idle();
    ID_Ra = 3; EX_Rw = 3; EX_RegWr = 1; EX_MemtoReg = 1;
    step("load_use");
    idle();
    ID_Ra = 3; Mem_Rw = 3; Mem_RegWr = 1; Mem_MemtoReg = 1;
    step("mem_load_nonbranch");
    // Mixed depths: Ra MEM load (1) vs Rb EX load (2) -> 2 wins.
    ID_Branch = 1; ID_UsesRb = 1; ID_Rb = 4;
    EX_Rw = 4; EX_RegWr = 1; EX_MemtoReg = 1;
    step("mixed_depth_run");
    idle();
    step("mixed_depth_hold");
    step("mixed_depth_done");

    // Async reset while in HOLD.
    ID_Branch = 1; ID_Ra = 6; EX_Rw = 6; EX_RegWr = 1; EX_MemtoReg = 1;
    step("hold_entry");
    #2;
    rst_n = 1'b0;
    owed = 0; m_stall = 0; m_taken = 0;
    #1;
    predict();
    check_all("async_reset");
    @(posedge clk);
    advance();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step("after_reset");

    // Randomized phase against the model.
    for (int i = 0; i < 300; i++) begin
      ID_Branch    = 1'($urandom_range(0, 1));
      ID_Ra        = 5'($urandom_range(0, 3));
      ID_Rb        = 5'($urandom_range(0, 3));
      ID_UsesRb    = 1'($urandom_range(0, 1));
      EX_Rw        = 5'($urandom_range(0, 3));
      Mem_Rw       = 5'($urandom_range(0, 3));
      EX_RegWr     = 1'($urandom_range(0, 1));
      Mem_RegWr    = 1'($urandom_range(0, 1));
      EX_MemtoReg  = 1'($urandom_range(0, 1));
      Mem_MemtoReg = 1'($urandom_range(0, 1));
      BranchTaken  = 1'($urandom_range(0, 1));
      Ext_Stall    = ($urandom_range(0, 7) == 0);
      step("random");
    end

    // Drive StallCycles up to FFFE with load-use bubbles, then saturate.
    idle();
    step("pre_sat_drain");
    step("pre_sat_drain2");
    ID_Ra = 2; EX_Rw = 2; EX_RegWr = 1; EX_MemtoReg = 1;
    while (m_stall < CNT_MAX - 1) tick();
    check("stall_fffe", 32'(StallCycles), 32'(CNT_MAX - 1));
    step("sat_1");
    step("sat_2");
    step("sat_3");
    check("stall_ffff", 32'(StallCycles), 32'(CNT_MAX));

    // Ext_Stall during a taken branch: no flush, counters hold.
    idle();
    ID_Branch = 1; BranchTaken = 1; Ext_Stall = 1;
    step("ext_stall_taken");
    Ext_Stall = 0;
    step("ext_stall_release");
    idle();
    step("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
